if_stage: RTL and testbench

- Instruction fetch stage of the pipelined core; transmitter side of the IF -> ID valid/notify handshake.
- Generates sequential PCs and issues word fetches to instruction memory, one outstanding request at a time.
- Buffers returned instructions with their PCs in a small FIFO and presents the head to the decode stage.
- Accepts a redirect (branch/jump) from the execute stage, which flushes all buffered and in-flight fetches.

---
 rtl/core_pkg.sv | 17 +
 rtl/if_fifo.sv | 49 ++++
 rtl/if_stage.sv | 137 +++++++++++++
 tb/tb_if_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM state encoding, datapath width and PC step.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO for {instr, pc} entries; pointers carry one extra wrap bit.
module if_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2 * XLEN
) (
  input  logic             clk,
  input  logic             resetn_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      wr_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);

  // A pop frees the slot in the same edge, so push-on-full is fine when paired with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn_i || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: sequential PCs, one outstanding imem fetch, {instr, pc} buffer to ID.
// Build option IF_MISALIGN_CHECK_EN: misaligned redirect target halts fetching until reset.
module if_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            resetn_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            notify_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
`ifdef IF_MISALIGN_CHECK_EN
  output logic            fetch_misaligned_o,
`endif
  output logic [1:0]      state_o
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_RESP = RESP;

  // Handshake to ID: valid_o offers the head; notify_i pulses one cycle after ID captured it,
  // popping the head on that edge. valid_o is masked during notify and branch cycles.

  logic [1:0]        state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [XLEN-1:0]   target;
  logic              halt;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*XLEN-1:0] fifo_head;

`ifdef IF_MISALIGN_CHECK_EN
  logic halt_q;

  assign target             = branch_target_i;
  assign halt               = halt_q;
  assign fetch_misaligned_o = halt_q;

  always_ff @(posedge clk) begin
    if (!resetn_i)                                halt_q <= 1'b0;
    else if (branch_i && |branch_target_i[1:0])   halt_q <= 1'b1;
  end
`else
  assign target = word_align(branch_target_i);
  assign halt   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    push    = 1'b0;
    unique case (state_q)
      // Nothing is outstanding in IDLE, so FIFO occupancy alone decides whether a slot remains.
      S_IDLE: if (!fifo_full && !halt) state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt_i) begin
          pc_d    = pc_q + PC_INC;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (imem_rvalid_i) begin
          push    = !kill_q;
          kill_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (branch_i) begin
      pc_d = target;
      push = 1'b0;
      case (state_q)
        S_REQ: begin
          kill_d  = imem_gnt_i;
          state_d = imem_gnt_i ? S_RESP : S_IDLE;
        end
        S_RESP: begin
          kill_d  = !imem_rvalid_i;
          state_d = imem_rvalid_i ? S_IDLE : S_RESP;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  // An unkilled response always belongs to the last grant, so its PC is pc_q minus one step.
  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk      (clk),
    .resetn_i (resetn_i),
    .push     (push),
    .wdata    ({imem_rdata_i, pc_q - PC_INC}),
    .pop      (notify_i && !branch_i),
    .flush    (branch_i),
    .rdata    (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign imem_req_o  = (state_q == S_REQ);
  assign imem_addr_o = pc_q;
  assign valid_o     = !fifo_empty && !notify_i && !branch_i;
  assign instr_o     = fifo_empty ? '0 : fifo_head[2*XLEN-1:XLEN];
  assign pc_o        = fifo_empty ? '0 : fifo_head[XLEN-1:0];
  assign state_o     = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: cycle vector table, directed redirect/stall/reset sequences, random traffic.
module tb_if_stage;
  import core_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        resetn_i, imem_req_o, imem_gnt_i, imem_rvalid_i, valid_o, notify_i, branch_i;
  logic [31:0] imem_addr_o, imem_rdata_i, instr_o, pc_o, branch_target_i;
  logic [1:0]  state_o;
`ifdef IF_MISALIGN_CHECK_EN
  logic        fetch_misaligned_o;
`endif

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .resetn_i           (resetn_i),
    .imem_req_o         (imem_req_o),
    .imem_addr_o        (imem_addr_o),
    .imem_gnt_i         (imem_gnt_i),
    .imem_rvalid_i      (imem_rvalid_i),
    .imem_rdata_i       (imem_rdata_i),
    .valid_o            (valid_o),
    .instr_o            (instr_o),
    .pc_o               (pc_o),
    .notify_i           (notify_i),
    .branch_i           (branch_i),
    .branch_target_i    (branch_target_i),
`ifdef IF_MISALIGN_CHECK_EN
    .fetch_misaligned_o (fetch_misaligned_o),
`endif
    .state_o            (state_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        rst_n, gnt, rvalid;
    logic [31:0] rdata;
    logic        notify;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr, exp_pc;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic vec_t mk(input logic rst_n, gnt, rv, input logic [31:0] rdata,
                              input logic notify, req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] instr, pc);
    vec_t v;
    v.rst_n = rst_n; v.gnt = gnt; v.rvalid = rv; v.rdata = rdata; v.notify = notify;
    v.exp_req = req; v.exp_addr = addr; v.exp_valid = valid; v.exp_instr = instr; v.exp_pc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle's inputs shortly after the active edge, then let outputs settle.
  task automatic drive(input logic rst_n, gnt, rv, input logic [31:0] rdata,
                       input logic notify, br, input logic [31:0] tgt);
    resetn_i = rst_n; imem_gnt_i = gnt; imem_rvalid_i = rv; imem_rdata_i = rdata;
    notify_i = notify; branch_i = br; branch_target_i = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          pend, epoch, g_epoch, captures;
    logic [31:0] fetch_pc, resp_addr, tgt, rdata;
    logic        rv, gnt, br, cap, cap_prev, busy;
    logic [63:0] e;

    // Clock/reset
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    check("reset_state", {30'b0, state_o}, {30'b0, IDLE});

    // Vector table: basic fetch, fill with ID stalled, one notify, refill request at addr 8
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0, 1'b0, 32'h0,         32'h0);
    vecs[3]  = mk(1'b1, 1'b0, 1'b1, 32'h13,        1'b0, 1'b0, 32'h4, 1'b0, 32'h0,         32'h0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h4, 1'b1, 32'h13,        32'h0);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4, 1'b1, 32'h13,        32'h0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b1, 32'h0040_0093, 1'b0, 1'b0, 32'h8, 1'b1, 32'h13,        32'h0);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8, 1'b1, 32'h13,        32'h0);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8, 1'b1, 32'h13,        32'h0);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8, 1'b0, 32'h13,        32'h0);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8, 1'b1, 32'h0040_0093, 32'h4);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8, 1'b1, 32'h0040_0093, 32'h4);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst_n, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].notify, 1'b0, 32'h0);
      check($sformatf("vec%0d_req", i),   {31'b0, imem_req_o}, {31'b0, vecs[i].exp_req});
      check($sformatf("vec%0d_addr", i),  imem_addr_o, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), {31'b0, valid_o}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_instr", i), instr_o, vecs[i].exp_instr);
      check($sformatf("vec%0d_pc", i),    pc_o, vecs[i].exp_pc);
      tick();
    end

    // Redirect while waiting for rvalid: the returning word must be dropped
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rq8_req", {31'b0, imem_req_o}, 32'h1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    check("br_resp_valid", {31'b0, valid_o}, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    check("stale_valid", {31'b0, valid_o}, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("drop_valid", {31'b0, valid_o}, 32'h0);
    check("drop_req", {31'b0, imem_req_o}, 32'h0);
    check("drop_addr", imem_addr_o, 32'h100);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("tgt_req", {31'b0, imem_req_o}, 32'h1);
    check("tgt_addr", imem_addr_o, 32'h100);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h0111_0113, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("tgt_head_valid", {31'b0, valid_o}, 32'h1);
    check("tgt_head_pc", pc_o, 32'h100);
    check("tgt_head_instr", instr_o, 32'h0111_0113);
    tick();

    // Branch, notify and rvalid together: flush wins, no push
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("seq_addr", imem_addr_o, 32'h104);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h0BAD_0BAD, 1'b1, 1'b1, 32'h200);
    check("triple_valid", {31'b0, valid_o}, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("triple_empty", {31'b0, valid_o}, 32'h0);
    check("triple_pc_o", pc_o, 32'h0);
    check("triple_instr_o", instr_o, 32'h0);
    check("triple_req", {31'b0, imem_req_o}, 32'h0);
    check("triple_pcq", imem_addr_o, 32'h200);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("t200_addr", imem_addr_o, 32'h200);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h0222_0113, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("t200_head_pc", pc_o, 32'h200);
    check("t200_head_instr", instr_o, 32'h0222_0113);
    tick();

    // Grant withheld: request held stable, then reset mid-wait with a late rvalid
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check($sformatf("stall%0d_req", i), {31'b0, imem_req_o}, 32'h1);
      check($sformatf("stall%0d_addr", i), imem_addr_o, 32'h204);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h0666_0113, 1'b0, 1'b0, 32'h0);
    check("rst_req", {31'b0, imem_req_o}, 32'h0);
    check("rst_valid", {31'b0, valid_o}, 32'h0);
    check("rst_addr", imem_addr_o, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("late_rvalid_valid", {31'b0, valid_o}, 32'h0);
    check("late_rvalid_req", {31'b0, imem_req_o}, 32'h1);
    tick();

    // Misaligned redirect while a request is pending without grant
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h102);
    tick();
`ifdef IF_MISALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check($sformatf("mis%0d_flag", i), {31'b0, fetch_misaligned_o}, 32'h1);
      check($sformatf("mis%0d_req", i), {31'b0, imem_req_o}, 32'h0);
      tick();
    end
`else
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("mis_idle_addr", imem_addr_o, 32'h100);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("mis_req", {31'b0, imem_req_o}, 32'h1);
    check("mis_addr", imem_addr_o, 32'h100);
    tick();
`endif

    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
`ifdef IF_MISALIGN_CHECK_EN
    check("mis_cleared", {31'b0, fetch_misaligned_o}, 32'h0);
`endif

    // Random traffic against a transaction-level model: epochs mark responses made stale by redirects
    pend = 0; epoch = 0; g_epoch = 0; captures = 0;
    fetch_pc = 32'h0; resp_addr = 32'h0; cap_prev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rv = 1'b0;
      rdata = 32'h0;
      if (pend > 0) begin
        pend--;
        rv = (pend == 0);
      end
      if (rv) rdata = mem_word(resp_addr);
      busy = (pend > 0) || rv;
      if (imem_req_o) check("one_outstanding", {31'b0, busy}, 32'h0);
      gnt = imem_req_o && ($urandom_range(0, 2) != 0);
      br  = ($urandom_range(0, 24) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
`ifdef IF_MISALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      if (gnt) begin
        check("fetch_addr", imem_addr_o, fetch_pc);
        resp_addr = fetch_pc;
        fetch_pc  = fetch_pc + 32'd4;
        pend      = $urandom_range(1, 3);
        g_epoch   = epoch;
      end
      if (rv && g_epoch == epoch && !br) begin
        check("fifo_room", {31'b0, exp_q.size() < DEPTH}, 32'h1);
        exp_q.push_back({rdata, resp_addr});
      end
      if (br) begin
        epoch++;
        exp_q.delete();
        fetch_pc = tgt & ~32'h3;
      end
      drive(1'b1, gnt, rv, rdata, cap_prev, br, tgt);
      if (br || cap_prev) check("valid_masked", {31'b0, valid_o}, 32'h0);
      cap = 1'b0;
      if (valid_o && $urandom_range(0, 1) == 1) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", {31'b0, valid_o}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("head_pc", pc_o, e[31:0]);
          check("head_instr", instr_o, e[63:32]);
          captures++;
          cap = 1'b1;
        end
      end
      cap_prev = cap;
      tick();
    end
    check("random_progress", {31'b0, captures >= 100}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
